// File: rtl/pi_pinmux_pkg.sv
// pi_pinmux_pkg: register map, pin-function encoding and debounce counter sizing
// shared by the pin mux top and its per-pin front end.
package pi_pinmux_pkg;

  localparam logic [4:0] OFF_FUNC    = 5'h00;
  localparam logic [4:0] OFF_RISE_EN = 5'h04;
  localparam logic [4:0] OFF_FALL_EN = 5'h08;
  localparam logic [4:0] OFF_STATUS  = 5'h0C;
  localparam logic [4:0] OFF_LEVEL   = 5'h10;

  typedef enum logic {
    PIN_GPIO = 1'b0,
    PIN_ALT  = 1'b1
  } pin_func_e;

  // The down-counter only ever holds DEB_CYCLES-1 .. 0, never DEB_CYCLES itself.
  function automatic int deb_cnt_w(input int deb_cycles);
    return (deb_cycles <= 2) ? 1 : $clog2(deb_cycles);
  endfunction

endpackage

// File: rtl/pi_pinmux_pin.sv
// pi_pinmux_pin: one header pin's input path -- two-flop synchroniser, optional
// debounce filter (PI_PINMUX_DEBOUNCE_EN) and filtered-level edge detector.
module pi_pinmux_pin
  import pi_pinmux_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1;
  logic r_sync2;
  logic r_level_q;
  logic w_level;

  // Bring the asynchronous pad level into the clk domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PI_PINMUX_DEBOUNCE_EN
  localparam int CNT_W = deb_cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Down-counter of remaining disagreeing samples; 0 means idle. The first
  // disagreeing sample loads DEB_CYCLES-1, so the level flips on the
  // DEB_CYCLES-th consecutive one. Any agreeing sample returns to idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if ((DEB_CYCLES == 1) || (r_cnt == CNT_TC)) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= CNT_LOAD;
    end else begin
      r_cnt <= r_cnt - CNT_TC;
    end
  end

  assign w_level = r_level;
`else
  localparam int unused_deb_cycles = DEB_CYCLES;

  assign w_level = r_sync2;
`endif

  // Previous filtered level, so a transition is seen the cycle after it lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_level_q;
  assign o_fall  = ~w_level & r_level_q;

endmodule

// File: rtl/pi_pinmux.sv
// pi_pinmux: header pin multiplexer between a GPIO controller and an alternate
// peripheral, with filtered input levels, per-pin edge capture and a level irq.
// Build option: define PI_PINMUX_DEBOUNCE_EN to insert the DEB_CYCLES filter.
module pi_pinmux
  import pi_pinmux_pkg::*;
#(
  parameter int N_PINS     = 28,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PINS-1:0] gpio_o,
  input  logic [N_PINS-1:0] gpio_t,
  output logic [N_PINS-1:0] gpio_i,
  input  logic [N_PINS-1:0] alt_o,
  input  logic [N_PINS-1:0] alt_t,
  output logic [N_PINS-1:0] alt_i,
  input  logic [N_PINS-1:0] pad_i,
  output logic [N_PINS-1:0] pad_o,
  output logic [N_PINS-1:0] pad_t,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [4:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              reg_ack,
  output logic              irq
);

  logic [N_PINS-1:0] r_func;
  logic [N_PINS-1:0] r_rise_en;
  logic [N_PINS-1:0] r_fall_en;
  logic [N_PINS-1:0] r_status;
  logic              r_irq;
  logic              r_ack;
  logic [31:0]       r_rdata;

  logic [N_PINS-1:0] w_level;
  logic [N_PINS-1:0] w_rise;
  logic [N_PINS-1:0] w_fall;
  logic [N_PINS-1:0] w_capture;
  logic [N_PINS-1:0] w_w1c;
  logic [N_PINS-1:0] w_wdata;
  logic [31:0]       w_rd_val;
  logic              w_hit_func;
  logic              w_hit_rise;
  logic              w_hit_fall;
  logic              w_hit_status;
  logic              w_unused_bits;

  // Only the word index matters; bits above N_PINS are dropped on write.
  assign w_wdata       = reg_wdata[N_PINS-1:0];
  assign w_unused_bits = ^{reg_addr[1:0], reg_wdata};

  assign w_hit_func   = (reg_addr[4:2] == OFF_FUNC[4:2]);
  assign w_hit_rise   = (reg_addr[4:2] == OFF_RISE_EN[4:2]);
  assign w_hit_fall   = (reg_addr[4:2] == OFF_FALL_EN[4:2]);
  assign w_hit_status = (reg_addr[4:2] == OFF_STATUS[4:2]);

  for (genvar n = 0; n < N_PINS; n++) begin : g_pin
    pi_pinmux_pin #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_pin (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_pad   (pad_i[n]),
      .o_level (w_level[n]),
      .o_rise  (w_rise[n]),
      .o_fall  (w_fall[n])
    );
  end

  assign gpio_i = w_level;
  assign alt_i  = w_level;

  // Pad drive select: combinational from FUNC so a write takes effect at once.
  always_comb begin
    pad_o = gpio_o;
    pad_t = gpio_t;
    for (int n = 0; n < N_PINS; n++) begin
      if (pin_func_e'(r_func[n]) == PIN_ALT) begin
        pad_o[n] = alt_o[n];
        pad_t[n] = alt_t[n];
      end
    end
  end

  // Read data mux; unmapped words and bits at or above N_PINS read 0.
  always_comb begin
    w_rd_val = '0;
    case (reg_addr[4:2])
      OFF_FUNC[4:2]:    w_rd_val[N_PINS-1:0] = r_func;
      OFF_RISE_EN[4:2]: w_rd_val[N_PINS-1:0] = r_rise_en;
      OFF_FALL_EN[4:2]: w_rd_val[N_PINS-1:0] = r_fall_en;
      OFF_STATUS[4:2]:  w_rd_val[N_PINS-1:0] = r_status;
      OFF_LEVEL[4:2]:   w_rd_val[N_PINS-1:0] = w_level;
      default:          w_rd_val = '0;
    endcase
  end

  assign w_capture = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_w1c     = (reg_wr && w_hit_status) ? w_wdata : '0;

  // Configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_func    <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (reg_wr) begin
      if (w_hit_func) r_func    <= w_wdata;
      if (w_hit_rise) r_rise_en <= w_wdata;
      if (w_hit_fall) r_fall_en <= w_wdata;
    end
  end

  // Edge status: clear first, then OR in captures so a same-cycle set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_w1c) | w_capture;
    end
  end

  // Interrupt is registered from the current status and enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & (r_rise_en | r_fall_en));
    end
  end

  // Bus response: one-cycle ack, read data sampled before any same-cycle write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= reg_wr | reg_rd;
      r_rdata <= reg_rd ? w_rd_val : '0;
    end
  end

  assign irq       = r_irq;
  assign reg_ack   = r_ack;
  assign reg_rdata = r_rdata;

endmodule

// File: doc/pi_pinmux.md
PI_PINMUX -- requirements
Module: pi_pinmux

Interface
REQ-001 Parameter N_PINS, default 28, number of header pins; legal range 1..32.
REQ-002 Parameter DEB_CYCLES, default 4, number of stable sync samples required before a filtered level changes; legal range 1..255.
REQ-003 Port clk  in  1  sole clock; all state is clocked on the rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Ports gpio_o / gpio_t  in  N_PINS  GPIO controller drive value / tristate (1 = input).
REQ-006 Port gpio_i  out  N_PINS  filtered pin level returned to the GPIO controller.
REQ-007 Ports alt_o / alt_t  in  N_PINS  alternate peripheral drive value / tristate.
REQ-008 Port alt_i  out  N_PINS  filtered pin level returned to the alternate peripheral.
REQ-009 Port pad_i  in  N_PINS  raw, asynchronous pad level.
REQ-010 Ports pad_o / pad_t  out  N_PINS  muxed pad drive value / tristate.
REQ-011 Ports reg_wr / reg_rd  in  1  single-cycle register write / read strobes.
REQ-012 Ports reg_addr  in  5 (byte address, bits 1:0 ignored); reg_wdata  in  32.
REQ-013 Ports reg_rdata  out  32; reg_ack  out  1.
REQ-014 Port irq  out  1  level interrupt.

Function
REQ-015 FUNC (0x00): bit n = 0 routes gpio_o/gpio_t to pad n; bit n = 1 routes alt_o/alt_t to pad n; the pad mux is combinational from the FUNC register.
REQ-016 gpio_i and alt_i both carry filtered level n at all times, regardless of FUNC.
REQ-017 Each pad_i bit passes through a 2-flop synchroniser.
REQ-018 With the filter in, filtered level n updates only after the synchronised value has differed from it for DEB_CYCLES consecutive cycles; any sample equal to the filtered level clears the counter.
REQ-019 RISE_EN (0x04) and FALL_EN (0x08) enable edge capture per pin.
REQ-020 A filtered 0->1 transition with RISE_EN[n], or 1->0 with FALL_EN[n], sets STATUS[n] (0x0C) on the following cycle.
REQ-021 STATUS is write-1-to-clear; if a set and a clear hit the same bit in the same cycle, set wins.
REQ-022 LEVEL (0x10) is read-only and returns the filtered levels.
REQ-023 irq = OR over n of (STATUS[n] & (RISE_EN[n] | FALL_EN[n])), registered, giving 1 cycle of latency.
REQ-024 reg_ack pulses exactly 1 cycle after reg_wr or reg_rd; reg_rdata is valid in that ack cycle and is 0 otherwise.
REQ-025 Unmapped addresses read 0, ignore writes, and still ack.
REQ-026 Register bits at or above N_PINS read 0 and ignore writes.
REQ-027 If reg_wr and reg_rd are asserted together, the write is performed and the read returns the pre-write value.

Reset
REQ-028 Reset clears FUNC, RISE_EN, FALL_EN, STATUS, the synchronisers, the filter counters and the filtered levels to 0.
REQ-029 During and after reset: pad_t = gpio_t, pad_o = gpio_o, irq = 0, reg_ack = 0, reg_rdata = 0.
REQ-030 Reset asserted mid-debounce discards the partial count, and no edge is captured for that transition.

Configuration
REQ-031 Macro PI_PINMUX_DEBOUNCE_EN, when defined, instantiates the DEB_CYCLES filter.
REQ-032 When PI_PINMUX_DEBOUNCE_EN is undefined, the filtered level equals the synchroniser output, DEB_CYCLES is ignored, and no counters are built.

Structure
REQ-033 Package pi_pinmux_pkg holds the register offsets (FUNC, RISE_EN, FALL_EN, STATUS, LEVEL), the pin-function enum (GPIO = 0, ALT = 1) and the counter width derived from DEB_CYCLES.
REQ-034 Sub-module pi_pinmux_pin contains the per-pin synchroniser, filter and edge detector and is generated N_PINS times.

Verification
REQ-035 After reset, drive gpio_o = 0x5, gpio_t = 0x0 -> pad_o = 0x5, pad_t = 0; write FUNC = 0x1 with alt_o[0] = 0 -> pad_o[0] = 0 on the cycle after ack.
REQ-036 With the filter in and DEB_CYCLES = 4, pulse pad_i[3] high for 3 cycles -> LEVEL[3] stays 0 and STATUS stays 0; hold it for 6 cycles -> LEVEL[3] = 1 after 2 + 4 cycles.
REQ-037 With RISE_EN = 0x8, a rising edge on pin 3 -> STATUS = 0x8 and irq = 1; write STATUS = 0x8 -> STATUS = 0 and irq = 0 within 2 cycles.
REQ-038 Arrange a capture on pin 3 in the same cycle as a W1C write of 0x8 -> STATUS[3] = 1.
REQ-039 Read 0x1C -> ack after 1 cycle with rdata = 0; with N_PINS = 8, write FUNC = 0xFFFF -> reads back 0xFF.
REQ-040 Assert reset mid-debounce -> all outputs take their reset values immediately; after release no STATUS bit is set.
